// File: rtl/mdu_if.sv
// HI/LO multiply-divide unit bus: launch/operands from the EX stage, status and
// architectural HI/LO back to the pipeline and hazard unit.
interface mdu_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HIWrite;
  logic        LOWrite;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, A, B, HIWrite, LOWrite,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, HIWrite, LOWrite,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// The result is computed combinationally from the operands presented with Start
// and parked in pending registers; a down-counter models the fixed latency and
// the pending value is committed to HI/LO on the last Busy edge.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  Clk,
  input  logic  Reset,
  mdu_if.slave  io
);

  localparam int DATA_W  = 32;
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic [DATA_W-1:0]         r_hi;
  logic [DATA_W-1:0]         r_lo;

  logic [DATA_W-1:0]         r_pend_hi_p0;
  logic [DATA_W-1:0]         r_pend_lo_p0;
  logic                      r_pend_wr_p0;

  logic [DATA_W-1:0]         w_res_hi;
  logic [DATA_W-1:0]         w_res_lo;
  logic                      w_res_wr;
  logic                      w_accept;

  // Signed 32x32 -> 64 product.
  function automatic logic [2*DATA_W-1:0] f_mul_s(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ea;
    logic signed [2*DATA_W-1:0] eb;
    logic signed [2*DATA_W-1:0] p;
    ea = $signed({{DATA_W{a[DATA_W-1]}}, a});
    eb = $signed({{DATA_W{b[DATA_W-1]}}, b});
    p  = ea * eb;
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [2*DATA_W-1:0] f_mul_u(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] ea;
    logic [2*DATA_W-1:0] eb;
    ea = {{DATA_W{1'b0}}, a};
    eb = {{DATA_W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Unsigned divide, returns {remainder, quotient}; a zero divisor yields zero
  // (the caller suppresses the commit in that case anyway).
  function automatic logic [2*DATA_W-1:0] f_div_u(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Signed divide on magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. Working on magnitudes keeps
  // 0x80000000 / -1 well defined (quotient wraps to 0x80000000, remainder 0).
  function automatic logic [2*DATA_W-1:0] f_div_s(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0]   ua;
    logic [DATA_W-1:0]   ub;
    logic [2*DATA_W-1:0] qr;
    logic [DATA_W-1:0]   q;
    logic [DATA_W-1:0]   r;
    ua = a[DATA_W-1] ? (~a + 1'b1) : a;
    ub = b[DATA_W-1] ? (~b + 1'b1) : b;
    qr = f_div_u(ua, ub);
    q  = qr[DATA_W-1:0];
    r  = qr[2*DATA_W-1:DATA_W];
    if (a[DATA_W-1] ^ b[DATA_W-1]) q = ~q + 1'b1;
    if (a[DATA_W-1])               r = ~r + 1'b1;
    return {r, q};
  endfunction

  assign w_accept = (r_state == S_IDLE) && io.Start;

  // Result of the operation presented this cycle; w_res_wr drops on divide by zero.
  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    w_res_wr = 1'b1;
    case (io.Op)
      2'b00: {w_res_hi, w_res_lo} = f_mul_s(io.A, io.B);
      2'b01: {w_res_hi, w_res_lo} = f_mul_u(io.A, io.B);
      2'b10: begin
        if (io.B == '0) w_res_wr = 1'b0;
        else            {w_res_hi, w_res_lo} = f_div_s(io.A, io.B);
      end
      default: begin
        if (io.B == '0) w_res_wr = 1'b0;
        else            {w_res_hi, w_res_lo} = f_div_u(io.A, io.B);
      end
    endcase
  end

  // ---- stage p0: pending result captured when an operation is accepted ----
  // Pending data only matters while BUSY, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_pend_hi_p0 <= w_res_hi;
      r_pend_lo_p0 <= w_res_lo;
      r_pend_wr_p0 <= w_res_wr;
    end
  end

  // ---- commit: IDLE/BUSY control, latency counter, HI/LO and mthi/mtlo ----
  // Start wins over mthi/mtlo in IDLE; every request is ignored while BUSY.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io.Start) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
            r_cnt   <= io.Op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else begin
            if (io.HIWrite) r_hi <= io.A;
            if (io.LOWrite) r_lo <= io.A;
          end
        end
        default: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            if (r_pend_wr_p0) begin
              r_hi <= r_pend_hi_p0;
              r_lo <= r_pend_lo_p0;
            end
          end
        end
      endcase
    end
  end

  assign io.Busy = r_busy;
  assign io.Done = r_done;
  assign io.HI   = r_hi;
  assign io.LO   = r_lo;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS datapath. It sits beside the ALU in the EX stage and holds the architectural HI/LO registers. `mfhi`/`mflo` results are taken from its HI/LO outputs and travel down the pipeline to the GRF write port. It executes `mult`/`multu`/`div`/`divu` over a fixed multi-cycle latency and exposes `Busy` so the hazard unit can stall dependent HI/LO instructions.

## Interface
- `MULT_CYCLES`, default 5: number of Busy cycles for a multiply.
- `DIV_CYCLES`, default 10: number of Busy cycles for a divide.
- `Clk`  in  1  system clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `Start`  in  1  launch the operation selected by `Op` this cycle.
- `Op`  in  2  operation: 00 `mult`, 01 `multu`, 10 `div`, 11 `divu`.
- `A`  in  32  rs operand; also the write data for `mthi`/`mtlo`.
- `B`  in  32  rt operand.
- `HIWrite`  in  1  `mthi`: HI <= A.
- `LOWrite`  in  1  `mtlo`: LO <= A.
- `Busy`  out  1  operation in flight.
- `Done`  out  1  one-cycle pulse in the first cycle new HI/LO are visible.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- Two states: IDLE and BUSY. A down-counter holds the remaining BUSY cycles.
- IDLE with Start=1 at a rising edge:
  - capture operands and Op;
  - compute the result into pending registers;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- BUSY:
  - the counter decrements each edge;
  - on the edge where the counter reaches its last cycle, commit pending→HI/LO, go to IDLE and set Done for one cycle.
  - HI/LO keep their old values for the whole BUSY period.
- Start while BUSY: ignored, with no restart and no queueing. The hazard unit guarantees this does not happen; the bench checks that it is ignored.
- HIWrite/LOWrite:
  - in IDLE, take effect at the next edge;
  - while BUSY, ignored;
  - if asserted together with Start in IDLE, Start wins and HIWrite/LOWrite are dropped.
- mult: signed 32×32 to 64-bit product; HI = product[63:32], LO = product[31:0].
- multu: same as mult, but unsigned.
- div (signed):
  - LO = quotient, truncated toward zero;
  - HI = remainder, carrying the sign of the dividend (A).
  - A = 0x80000000, B = 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- divu: unsigned quotient in LO, remainder in HI.
- Divide by zero (B = 0): the full DIV_CYCLES Busy period still runs, and HI/LO are left unchanged at commit.
- Reset (low), asynchronous:
  - state goes to IDLE and the counter to 0;
  - Busy = 0, Done = 0, HI = 0, LO = 0;
  - any pending result is discarded.

## Timing
- Start is sampled at edge E0. Busy = 1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES), on edges E0..E(N−1).
- HI/LO are updated at edge EN. From that edge: Busy = 0 and Done = 1 for one cycle.
- Start may be reasserted in the cycle Done = 1; it is accepted at E(N+1).
- Busy is a registered output and is never combinationally dependent on Start. The hazard unit forms the stall condition as `Start | Busy`.
- HIWrite/LOWrite results are visible the cycle after the edge that samples them.
- HI/LO are plain register outputs; there is no read bypass.

## Test plan
- **mult:** Op=00, A=0xFFFFFFFF, B=2, Start for 1 cycle.
  - Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE with Done pulsed.
  - Repeat with Op=01 (multu): HI=0x00000001, LO=0xFFFFFFFE.
- **div/divu:** Op=10, A=0xFFFFFFF9 (−7), B=2.
  - After 10 Busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - Op=11 with A=7, B=2 gives LO=3, HI=1.
  - Op=10 with A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Divide by zero:** preload HI=0x1234 and LO=0x5678 via mthi/mtlo, then div with B=0.
  - Busy still lasts 10 cycles; HI/LO remain 0x1234/0x5678.
- **Ignored inputs while BUSY:** start mult 3×4, then assert Start (div) and HIWrite (A=0xDEAD) in busy cycle 2.
  - Busy ends after 5 cycles from the first Start; HI=0, LO=12, no div is launched.
- **Back-to-back:** reassert Start (multu 0x10000×0x10000) in the Done cycle.
  - The second op is accepted with no gap; after 5 more cycles HI=1, LO=0.
- **Reset mid-operation:** drive Reset low asynchronously in busy cycle 3 of a div (between edges).
  - Busy, Done, HI and LO go to 0 immediately, and no commit occurs after Reset is released.
